// File: rtl/gpu_pkg.sv
// Shared definitions for the GPU write scheduler: memory-map bases, region
// widths, the region enum and the address-to-region decode helper.
package gpu_pkg;

   localparam logic [15:0] GPU_TILE_BASE  = 16'h0000;
   localparam logic [15:0] GPU_ATTR_BASE  = 16'h0800;
   localparam logic [15:0] GPU_COLOR_BASE = 16'h1800;

   localparam int GPU_TILE_AW  = 11;
   localparam int GPU_ATTR_AW  = 12;
   localparam int GPU_COLOR_AW = 4;

   typedef enum logic [1:0] {
      TILE,
      ATTR,
      COLOR
   } gpu_region_t;

   typedef enum logic {
      FILL_IDLE,
      FILL_RUN
   } gpu_fill_state_t;

   function automatic gpu_region_t gpu_decode(input logic [15:0] addr);
      if (addr < GPU_ATTR_BASE) begin
         return TILE;
      end else if (addr < GPU_COLOR_BASE) begin
         return ATTR;
      end
      return COLOR;
   endfunction

endpackage

// File: rtl/gpu_fill_sequencer.sv
// Fill sequencer: walks an address range writing a constant byte, one byte per
// granted slot, and pulses done with the strobe of the last byte.
module gpu_fill_sequencer
   import gpu_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        fill_start,
   input  logic [15:0] fill_base,
   input  logic [15:0] fill_len,
   input  logic [7:0]  fill_value,
   input  logic        grant,
   output logic        busy,
   output logic [15:0] addr,
   output logic [7:0]  value,
   output logic        done
);

   gpu_fill_state_t state_q, state_d;
   logic [15:0]     addr_q, addr_d;
   logic [15:0]     count_q, count_d;
   logic [7:0]      value_q, value_d;
   logic            done_q, done_d;

   // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      count_d = count_q;
      value_d = value_q;
      done_d  = 1'b0;
      case (state_q)
         FILL_IDLE: begin
            if (fill_start) begin
               if (fill_len != 16'd0) begin
                  state_d = FILL_RUN;
                  addr_d  = fill_base;
                  count_d = fill_len;
                  value_d = fill_value;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         FILL_RUN: begin
            if (grant) begin
               addr_d  = addr_q + 16'd1;
               count_d = count_q - 16'd1;
               // done is registered, so it lands on the same edge as the last strobe
               if (count_q == 16'd1) begin
                  state_d = FILL_IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = FILL_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= FILL_IDLE;
         addr_q  <= '0;
         count_q <= '0;
         value_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         value_q <= value_d;
         done_q  <= done_d;
      end
   end

   assign busy  = (state_q == FILL_RUN);
   assign addr  = addr_q;
   assign value = value_q;
   assign done  = done_q;

endmodule

// File: rtl/gpu_write_scheduler.sv
// Owns the tile/attribute/colour write ports: CPU holding register, CPU-vs-fill
// arbiter, region decode and registered write outputs. Fill built only with GPU_FILL_EN.
module gpu_write_scheduler
   import gpu_pkg::*;
#(
   parameter int unsigned MAX_CPU_RUN = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_valid,
   input  logic [15:0] cpu_addr,
   input  logic [7:0]  cpu_data,
   output logic        cpu_ready,
   input  logic        fill_start,
   input  logic [15:0] fill_base,
   input  logic [15:0] fill_len,
   input  logic [7:0]  fill_value,
   output logic        fill_busy,
   output logic        fill_done,
   output logic        tile_memory_write_enable,
   output logic [10:0] tile_memory_write_addr,
   output logic [7:0]  tile_memory_write_data,
   output logic        attribute_memory_write_enable,
   output logic [11:0] attribute_memory_write_addr,
   output logic [7:0]  attribute_memory_write_data,
   output logic        color_memory_write_enable,
   output logic [3:0]  color_memory_write_addr,
   output logic [7:0]  color_memory_write_data
);

   localparam logic [3:0] STREAK_MAX = 4'(MAX_CPU_RUN);

   logic        hold_valid_q, hold_valid_d;
   logic [15:0] hold_addr_q, hold_addr_d;
   logic [7:0]  hold_data_q, hold_data_d;

   logic        grant_cpu, grant_fill;
   logic [15:0] fill_addr;
   logic [7:0]  fill_byte;

`ifdef GPU_FILL_EN
   logic       fill_req;
   logic [3:0] streak_q, streak_d;

   gpu_fill_sequencer u_fill (
      .clk        (clk),
      .rst        (rst),
      .fill_start (fill_start),
      .fill_base  (fill_base),
      .fill_len   (fill_len),
      .fill_value (fill_value),
      .grant      (grant_fill),
      .busy       (fill_req),
      .addr       (fill_addr),
      .value      (fill_byte),
      .done       (fill_done)
   );

   // CPU has priority until it has won STREAK_MAX slots in a row over a waiting fill
   always_comb begin
      grant_fill = fill_req && (!hold_valid_q || streak_q == STREAK_MAX);
      grant_cpu  = hold_valid_q && !grant_fill;
      streak_d   = streak_q;
      if (!fill_req || grant_fill) begin
         streak_d = 4'd0;
      end else if (grant_cpu) begin
         streak_d = streak_q + 4'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         streak_q <= 4'd0;
      end else begin
         streak_q <= streak_d;
      end
   end

   assign fill_busy = fill_req;
`else
   logic unused_fill;
   assign unused_fill = ^{fill_start, fill_base, fill_len, fill_value, STREAK_MAX};
   assign grant_cpu   = hold_valid_q;
   assign grant_fill  = 1'b0;
   assign fill_addr   = '0;
   assign fill_byte   = '0;
   assign fill_busy   = 1'b0;
   assign fill_done   = 1'b0;
`endif

   // Emptied by a grant and refilled by an accept in the same cycle.
   assign cpu_ready = !hold_valid_q || grant_cpu;

   always_comb begin
      hold_valid_d = hold_valid_q;
      hold_addr_d  = hold_addr_q;
      hold_data_d  = hold_data_q;
      if (grant_cpu) begin
         hold_valid_d = 1'b0;
      end
      if (cpu_valid && cpu_ready) begin
         hold_valid_d = 1'b1;
         hold_addr_d  = cpu_addr;
         hold_data_d  = cpu_data;
      end
   end

   logic [15:0]  wr_addr;
   logic [7:0]   wr_data;
   gpu_region_t  wr_region;

   logic        tile_we_q, tile_we_d;
   logic [10:0] tile_addr_q, tile_addr_d;
   logic [7:0]  tile_data_q, tile_data_d;
   logic        attr_we_q, attr_we_d;
   logic [11:0] attr_addr_q, attr_addr_d;
   logic [7:0]  attr_data_q, attr_data_d;
   logic        color_we_q, color_we_d;
   logic [3:0]  color_addr_q, color_addr_d;
   logic [7:0]  color_data_q, color_data_d;

   always_comb begin
      wr_addr   = grant_cpu ? hold_addr_q : fill_addr;
      wr_data   = grant_cpu ? hold_data_q : fill_byte;
      wr_region = gpu_decode(wr_addr);

      tile_we_d    = 1'b0;
      tile_addr_d  = tile_addr_q;
      tile_data_d  = tile_data_q;
      attr_we_d    = 1'b0;
      attr_addr_d  = attr_addr_q;
      attr_data_d  = attr_data_q;
      color_we_d   = 1'b0;
      color_addr_d = color_addr_q;
      color_data_d = color_data_q;

      if (grant_cpu || grant_fill) begin
         case (wr_region)
            TILE: begin
               tile_we_d   = 1'b1;
               tile_addr_d = GPU_TILE_AW'(wr_addr - GPU_TILE_BASE);
               tile_data_d = wr_data;
            end
            ATTR: begin
               attr_we_d   = 1'b1;
               attr_addr_d = GPU_ATTR_AW'(wr_addr - GPU_ATTR_BASE);
               attr_data_d = wr_data;
            end
            default: begin
               color_we_d   = 1'b1;
               color_addr_d = GPU_COLOR_AW'(wr_addr - GPU_COLOR_BASE);
               color_data_d = wr_data;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         hold_valid_q <= 1'b0;
         hold_addr_q  <= '0;
         hold_data_q  <= '0;
         tile_we_q    <= 1'b0;
         tile_addr_q  <= '0;
         tile_data_q  <= '0;
         attr_we_q    <= 1'b0;
         attr_addr_q  <= '0;
         attr_data_q  <= '0;
         color_we_q   <= 1'b0;
         color_addr_q <= '0;
         color_data_q <= '0;
      end else begin
         hold_valid_q <= hold_valid_d;
         hold_addr_q  <= hold_addr_d;
         hold_data_q  <= hold_data_d;
         tile_we_q    <= tile_we_d;
         tile_addr_q  <= tile_addr_d;
         tile_data_q  <= tile_data_d;
         attr_we_q    <= attr_we_d;
         attr_addr_q  <= attr_addr_d;
         attr_data_q  <= attr_data_d;
         color_we_q   <= color_we_d;
         color_addr_q <= color_addr_d;
         color_data_q <= color_data_d;
      end
   end

   assign tile_memory_write_enable      = tile_we_q;
   assign tile_memory_write_addr        = tile_addr_q;
   assign tile_memory_write_data        = tile_data_q;
   assign attribute_memory_write_enable = attr_we_q;
   assign attribute_memory_write_addr   = attr_addr_q;
   assign attribute_memory_write_data   = attr_data_q;
   assign color_memory_write_enable     = color_we_q;
   assign color_memory_write_addr       = color_addr_q;
   assign color_memory_write_data       = color_data_q;

endmodule
